// File: rtl/r128a32_ram.sv
// 128 x 32 simple dual-port RAM: synchronous write port, combinational read port.
// The async clear empties the whole array so the FIFO above it starts from known data.
module r128a32_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Reset beats a coincident write: the clear branch is taken whenever reset is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  // No bypass from wd: a same-address write shows up only once the array updates.
  assign rd = mem_q[ra];

endmodule

// File: tb/tb_r128a32_ram.sv
// Directed self-checking bench for r128a32_ram.
// Each task drives one scenario and checks rd against hand-computed words.
module tb_r128a32_ram;

  logic        clock;
  logic        reset;
  logic        we;
  logic [6:0]  wa;
  logic [31:0] wd;
  logic [6:0]  ra;
  logic [31:0] rd;
  logic        clk_en;

  int checks;
  int failures;

  r128a32_ram dut (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra    (ra),
    .rd    (rd)
  );

  initial begin
    clock  = 1'b0;
    clk_en = 1'b1;
    forever begin
      #5;
      if (clk_en) clock = ~clock;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic do_write(input logic [6:0] a, input logic [31:0] d);
    @(negedge clock);
    we = 1'b1;
    wa = a;
    wd = d;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_write(7'd5, 32'hDEADBEEF);
    ra = 7'd5;
    #1;
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_prewrite: rd=%h expected=%h", rd, 32'hDEADBEEF);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_immediate: rd=%h expected=%h", rd, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 128; i++) begin
      ra = i[6:0];
      #1;
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL reset_clear ra=%0d: rd=%h expected=%h", i, rd, 32'h0);
      end
    end
  endtask

  task automatic test_we_gating();
    @(negedge clock);
    we = 1'b0;
    wa = 7'd3;
    wd = 32'h12345678;
    ra = 7'd3;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL we_gating: rd=%h expected=%h", rd, 32'h0);
    end
  endtask

  task automatic test_readback();
    logic [31:0] exp;
    for (int i = 0; i < 128; i++) begin
      do_write(i[6:0], 32'hA5A50000 + i);
    end
    for (int i = 0; i < 128; i++) begin
      ra  = i[6:0];
      exp = 32'hA5A50000 + i;
      #1;
      checks++;
      if (rd !== exp) begin
        failures++;
        $display("FAIL readback ra=%0d: rd=%h expected=%h", i, rd, exp);
      end
    end
  endtask

  task automatic test_collision();
    do_write(7'd10, 32'h11111111);
    @(negedge clock);
    ra = 7'd10;
    wa = 7'd10;
    wd = 32'h22222222;
    we = 1'b1;
    #1;
    checks++;
    if (rd !== 32'h11111111) begin
      failures++;
      $display("FAIL collision_before: rd=%h expected=%h", rd, 32'h11111111);
    end
    @(posedge clock);
    #1;
    we = 1'b0;
    checks++;
    if (rd !== 32'h22222222) begin
      failures++;
      $display("FAIL collision_after: rd=%h expected=%h", rd, 32'h22222222);
    end
  endtask

  task automatic test_async_read();
    logic [6:0]  addrs [3];
    logic [31:0] exps  [3];
    addrs[0] = 7'd0;   exps[0] = 32'hA5A50000;
    addrs[1] = 7'd64;  exps[1] = 32'hA5A50040;
    addrs[2] = 7'd127; exps[2] = 32'hA5A5007F;
    @(negedge clock);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #7;
      ra = addrs[i];
      #1;
      checks++;
      if (rd !== exps[i]) begin
        failures++;
        $display("FAIL async_read ra=%0d: rd=%h expected=%h", addrs[i], rd, exps[i]);
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset_during_write();
    @(negedge clock);
    we    = 1'b1;
    wa    = 7'd7;
    wd    = 32'hFFFFFFFF;
    ra    = 7'd7;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_write_during: rd=%h expected=%h", rd, 32'h0);
    end
    @(negedge clock);
    we    = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_write_after: rd=%h expected=%h", rd, 32'h0);
    end
    ra = 7'd127;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_write_other: rd=%h expected=%h", rd, 32'h0);
    end
    // first edge after reset release must accept a write
    we = 1'b1;
    wa = 7'd7;
    wd = 32'h00007777;
    ra = 7'd7;
    @(posedge clock);
    #1;
    we = 1'b0;
    checks++;
    if (rd !== 32'h00007777) begin
      failures++;
      $display("FAIL first_write_after_reset: rd=%h expected=%h", rd, 32'h00007777);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    ra       = '0;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("FAIL initial_reset: rd=%h expected=%h", rd, 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;

    test_reset();
    test_we_gating();
    test_readback();
    test_collision();
    test_async_read();
    test_reset_during_write();
    pulse_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
